// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port (fetch/data) arbiter and registered address driver for a combinational ROM; define ROM_ARB_RR_EN for round-robin
module rom_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int ROM_DEPTH = 10,
  parameter int MAX_WAIT  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t r_state;
  logic   r_owner;
  logic   w_pick_d;
  logic   w_oor;
  assign w_oor = rom_addr >= ADDR_W'(ROM_DEPTH);
  assign busy  = r_state == ACCESS;
`ifdef ROM_ARB_RR_EN
  logic r_last_owner;
  assign w_pick_d = d_req & (~f_req | ~r_last_owner);
  // remember the most recent winner so contention alternates
  always_ff @(posedge CLK)
    if (RST) r_last_owner <= 1'b1;
    else if (r_state == IDLE && (f_req || d_req)) r_last_owner <= w_pick_d;
`else
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] r_wait_cnt;
  assign w_pick_d = d_req & (~f_req | (r_wait_cnt == WAIT_W'(MAX_WAIT)));
  // count F grants that bypass a waiting D; D is forced once the count hits MAX_WAIT
  always_ff @(posedge CLK)
    if (RST) r_wait_cnt <= '0;
    else if (r_state == IDLE) begin
      if (!d_req || w_pick_d) r_wait_cnt <= '0;
      else if (f_req && r_wait_cnt != WAIT_W'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + 1'b1;
    end
`endif
  // grant in IDLE, return the ROM word to the owner in ACCESS
  always_ff @(posedge CLK)
    if (RST) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      rom_addr <= '0;
      f_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      f_err    <= 1'b0;
      d_err    <= 1'b0;
      f_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      f_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      f_err    <= 1'b0;
      d_err    <= 1'b0;
      if (r_state == IDLE) begin
        if (f_req || d_req) begin
          rom_addr <= w_pick_d ? d_addr : f_addr;
          r_owner  <= w_pick_d;
          f_gnt    <= ~w_pick_d;
          d_gnt    <= w_pick_d;
          r_state  <= ACCESS;
        end
      end else begin
        if (r_owner) begin
          d_rdata  <= rom_data;
          d_rvalid <= 1'b1;
          d_err    <= w_oor;
        end else begin
          f_rdata  <= rom_data;
          f_rvalid <= 1'b1;
          f_err    <= w_oor;
        end
        r_state <= IDLE;
      end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter with a behavioural ROM
module tb_rom_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0;
  logic [15:0] f_addr = '0, d_addr = '0;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, busy;
  logic [31:0] f_rdata, d_rdata, rom_data;
  logic [15:0] rom_addr, held_addr;
  logic [31:0] rom [10];
  logic [31:0] exp_data;
  logic [5:0]  seq;
  int          checks = 0, errors = 0;
  int          fa;

  rom_arbiter dut (
    .CLK(CLK), .RST(RST),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  assign rom_data = (rom_addr < 16'd10) ? rom[rom_addr[3:0]] : 32'h0;

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rom[0] = 32'h11110000; rom[1] = 32'h22220001; rom[2] = 32'h33330002; rom[3] = 32'h0000401A;
    rom[4] = 32'h44440004; rom[5] = 32'h55550005; rom[6] = 32'h66660006; rom[7] = 32'h00086042;
    rom[8] = 32'h00030188; rom[9] = 32'h99990009;
`ifdef ROM_ARB_RR_EN
    seq = 6'b101010;
`else
    seq = 6'b010000;
`endif
    step; step;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_gnt", {30'b0, f_gnt, d_gnt}, 0);
    chk("rst_rvalid", {30'b0, f_rvalid, d_rvalid}, 0);
    chk("rst_err", {30'b0, f_err, d_err}, 0);
    chk("rst_f_rdata", f_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_rom_addr", {16'b0, rom_addr}, 0);
    RST = 1'b0;
    // F only
    f_req = 1'b1; f_addr = 16'h0003;
    step;
    chk("t1_f_gnt", {31'b0, f_gnt}, 1);
    chk("t1_busy", {31'b0, busy}, 1);
    chk("t1_rom_addr", {16'b0, rom_addr}, 32'h3);
    f_req = 1'b0;
    step;
    chk("t1_f_rvalid", {31'b0, f_rvalid}, 1);
    chk("t1_f_gnt_low", {31'b0, f_gnt}, 0);
    chk("t1_f_rdata", f_rdata, 32'h0000401A);
    chk("t1_f_err", {31'b0, f_err}, 0);
    chk("t1_d_rvalid", {31'b0, d_rvalid}, 0);
    // D out of range
    d_req = 1'b1; d_addr = 16'h000A;
    step;
    chk("t2_d_gnt", {31'b0, d_gnt}, 1);
    chk("t2_f_gnt", {31'b0, f_gnt}, 0);
    d_req = 1'b0;
    step;
    chk("t2_d_rvalid", {31'b0, d_rvalid}, 1);
    chk("t2_d_rdata", d_rdata, 0);
    chk("t2_d_err", {31'b0, d_err}, 1);
    chk("t2_f_rvalid", {31'b0, f_rvalid}, 0);
    chk("t2_f_err", {31'b0, f_err}, 0);
    chk("t2_f_rdata", f_rdata, 32'h0000401A);
    // contention
    f_req = 1'b1; d_req = 1'b1; fa = 0; f_addr = 16'(fa); d_addr = 16'h0009;
    for (int i = 0; i < 6; i++) begin
      step;
      chk($sformatf("t3_f_gnt%0d", i), {31'b0, f_gnt}, {31'b0, ~seq[i]});
      chk($sformatf("t3_d_gnt%0d", i), {31'b0, d_gnt}, {31'b0, seq[i]});
      exp_data = seq[i] ? rom[9] : rom[fa];
      if (!seq[i]) fa++;
      f_addr = 16'(fa);
      if (i == 5) begin f_req = 1'b0; d_req = 1'b0; end
      step;
      chk($sformatf("t3_f_rv%0d", i), {31'b0, f_rvalid}, {31'b0, ~seq[i]});
      chk($sformatf("t3_d_rv%0d", i), {31'b0, d_rvalid}, {31'b0, seq[i]});
      chk($sformatf("t3_rdata%0d", i), seq[i] ? d_rdata : f_rdata, exp_data);
    end
    // back-to-back F
    f_req = 1'b1; f_addr = 16'h0007;
    step;
    chk("t4_gnt1", {31'b0, f_gnt}, 1);
    f_addr = 16'h0008;
    step;
    chk("t4_rv2", {31'b0, f_rvalid}, 1);
    chk("t4_gnt2_low", {31'b0, f_gnt}, 0);
    chk("t4_rdata2", f_rdata, 32'h00086042);
    step;
    chk("t4_gnt3", {31'b0, f_gnt}, 1);
    chk("t4_rv3_low", {31'b0, f_rvalid}, 0);
    f_req = 1'b0;
    step;
    chk("t4_rv4", {31'b0, f_rvalid}, 1);
    chk("t4_rdata4", f_rdata, 32'h00030188);
    // reset during ACCESS
    f_req = 1'b1; f_addr = 16'h0003;
    step;
    chk("t5_busy", {31'b0, busy}, 1);
    RST = 1'b1; f_req = 1'b0;
    step;
    chk("t5_rvalid", {31'b0, f_rvalid}, 0);
    chk("t5_rom_addr", {16'b0, rom_addr}, 0);
    chk("t5_busy_low", {31'b0, busy}, 0);
    chk("t5_f_rdata", f_rdata, 0);
    RST = 1'b0;
    // idle hold after a D access to word 5
    d_req = 1'b1; d_addr = 16'h0005;
    step;
    d_req = 1'b0;
    step;
    chk("t6_d_rdata", d_rdata, 32'h55550005);
    held_addr = 16'h0005;
    for (int i = 0; i < 20; i++) begin
      step;
      chk($sformatf("t6_busy%0d", i), {31'b0, busy}, 0);
      chk($sformatf("t6_gnt%0d", i), {30'b0, f_gnt, d_gnt}, 0);
      chk($sformatf("t6_rv%0d", i), {30'b0, f_rvalid, d_rvalid}, 0);
      chk($sformatf("t6_addr%0d", i), {16'b0, rom_addr}, {16'b0, held_addr});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
